// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width, flag bit positions and the
// expected/observed response tuple layout {flags, result}.
package alu_pkg;

  localparam int ALU_W      = 32;
  localparam int FLAGS_W    = 3;
  localparam int FLAG_OF    = 2;
  localparam int FLAG_CARRY = 1;
  localparam int FLAG_EQ    = 0;

  typedef struct packed {
    logic [FLAGS_W-1:0] flags;
    logic [ALU_W-1:0]   result;
  } alu_resp_t;

endpackage

// File: rtl/alu_result_checker_resp_fifo.sv
// Small synchronous FIFO holding expected response tuples, with flush and an
// occupancy count one bit wider than the pointers so full and empty differ.
module resp_fifo #(
  parameter int W     = 35,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == {CW{1'b0}});

  // Storage array; entries beyond count are don't-care but reset for determinism.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= {W{1'b0}};
      end
    end else if (push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= {AW{1'b0}};
      rd_ptr <= {AW{1'b0}};
      count  <= {CW{1'b0}};
    end else if (flush) begin
      wr_ptr <= {AW{1'b0}};
      rd_ptr <= {AW{1'b0}};
      count  <= {CW{1'b0}};
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_result_checker.sv
// Consuming end of the ALU stimulus path: queues expected tuples, compares each
// observed ALU output with the oldest one, and keeps counts plus a first-fail capture.
module alu_result_checker
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      exp_valid,
  output logic                      exp_ready,
  input  logic [WIDTH-1:0]          exp_result,
  input  logic [FLAGS_W-1:0]        exp_flags,
  input  logic                      obs_valid,
  input  logic [WIDTH-1:0]          obs_result,
  input  logic [FLAGS_W-1:0]        obs_flags,
  input  logic                      clear,
  output logic [$clog2(DEPTH):0]    pending,
  output logic                      mismatch,
  output logic                      match,
  output logic [CNT_W-1:0]          pass_count,
  output logic [CNT_W-1:0]          fail_count,
  output logic                      underflow,
  output logic                      error_sticky,
  output logic [WIDTH+FLAGS_W-1:0]  first_fail_obs,
  output logic [WIDTH+FLAGS_W-1:0]  first_fail_exp
);

  localparam int TW = WIDTH + FLAGS_W;

  logic          fifo_full;
  logic          fifo_empty;
  logic [TW-1:0] head;
  logic [TW-1:0] exp_word;
  logic [TW-1:0] obs_word;
  logic          push_en;
  logic          pop_en;
  logic          is_equal;

  // Clear suppresses both FIFO operations; an empty FIFO never bypasses a same-cycle push.
  always_comb begin
    exp_word = {exp_flags, exp_result};
    obs_word = {obs_flags, obs_result};
    push_en  = exp_valid && !fifo_full && !clear;
    pop_en   = obs_valid && !fifo_empty && !clear;
    is_equal = (obs_word == head);
  end

  assign exp_ready = !fifo_full;

  resp_fifo #(
    .W     (TW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (clear),
    .push      (push_en),
    .push_data (exp_word),
    .pop       (pop_en),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (pending)
  );

  // Compare stage: the popped head and observation resolve into a registered pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match          <= 1'b0;
      mismatch       <= 1'b0;
      pass_count     <= {CNT_W{1'b0}};
      fail_count     <= {CNT_W{1'b0}};
      underflow      <= 1'b0;
      error_sticky   <= 1'b0;
      first_fail_obs <= {TW{1'b0}};
      first_fail_exp <= {TW{1'b0}};
    end else if (clear) begin
      match          <= 1'b0;
      mismatch       <= 1'b0;
      pass_count     <= {CNT_W{1'b0}};
      fail_count     <= {CNT_W{1'b0}};
      underflow      <= 1'b0;
      error_sticky   <= 1'b0;
      first_fail_obs <= {TW{1'b0}};
      first_fail_exp <= {TW{1'b0}};
    end else begin
      match    <= pop_en && is_equal;
      mismatch <= pop_en && !is_equal;
      if (obs_valid && fifo_empty) begin
        underflow <= 1'b1;
      end
      if (pop_en && is_equal && (pass_count != {CNT_W{1'b1}})) begin
        pass_count <= pass_count + CNT_W'(1);
      end
      if (pop_en && !is_equal) begin
        error_sticky <= 1'b1;
        if (fail_count != {CNT_W{1'b1}}) begin
          fail_count <= fail_count + CNT_W'(1);
        end
        if (!error_sticky) begin
          first_fail_obs <= obs_word;
          first_fail_exp <= head;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_result_checker.sv
// Scoreboard bench: a queue-based reference model predicts each compare outcome
// and the checker's visible state; a monitor checks pulses and state every cycle.
module tb_alu_result_checker;
  import alu_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = 4;
  localparam int PW    = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 exp_valid = 1'b0;
  logic                 exp_ready;
  logic [ALU_W-1:0]     exp_result = '0;
  logic [FLAGS_W-1:0]   exp_flags = '0;
  logic                 obs_valid = 1'b0;
  logic [ALU_W-1:0]     obs_result = '0;
  logic [FLAGS_W-1:0]   obs_flags = '0;
  logic                 clear = 1'b0;
  logic [PW-1:0]        pending;
  logic                 mismatch;
  logic                 match;
  logic [CNT_W-1:0]     pass_count;
  logic [CNT_W-1:0]     fail_count;
  logic                 underflow;
  logic                 error_sticky;
  logic [ALU_W+2:0]     first_fail_obs;
  logic [ALU_W+2:0]     first_fail_exp;

  alu_result_checker #(.WIDTH(ALU_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .exp_valid(exp_valid), .exp_ready(exp_ready),
    .exp_result(exp_result), .exp_flags(exp_flags), .obs_valid(obs_valid),
    .obs_result(obs_result), .obs_flags(obs_flags), .clear(clear),
    .pending(pending), .mismatch(mismatch), .match(match),
    .pass_count(pass_count), .fail_count(fail_count), .underflow(underflow),
    .error_sticky(error_sticky), .first_fail_obs(first_fail_obs),
    .first_fail_exp(first_fail_exp)
  );

  always #5 clk = ~clk;

  // Reference model state
  alu_resp_t mq[$];
  bit        sb[$];
  int        pass_m, fail_m;
  bit        under_m, err_m;
  alu_resp_t ffo_m, ffe_m;
  int        checks = 0;
  int        errors = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endfunction

  function automatic alu_resp_t mk(logic [ALU_W-1:0] r, logic [2:0] f);
    alu_resp_t t;
    t.result = r;
    t.flags  = f;
    return t;
  endfunction

  function automatic void model_reset();
    mq.delete();
    sb.delete();
    pass_m = 0; fail_m = 0; under_m = 0; err_m = 0;
    ffo_m = '0; ffe_m = '0;
  endfunction

  // Apply one cycle of stimulus at the falling edge and predict the next rising edge.
  task automatic drive(input bit ev, input alu_resp_t e, input bit ov, input alu_resp_t o,
                       input bit clr);
    alu_resp_t h;
    bit do_push, do_pop;
    @(negedge clk);
    exp_valid = ev; exp_result = e.result; exp_flags = e.flags;
    obs_valid = ov; obs_result = o.result; obs_flags = o.flags;
    clear = clr;
    if (clr) begin
      mq.delete();
      pass_m = 0; fail_m = 0; under_m = 0; err_m = 0;
      ffo_m = '0; ffe_m = '0;
    end else begin
      do_push = ev && (mq.size() < DEPTH);
      do_pop  = ov && (mq.size() > 0);
      if (ov && mq.size() == 0) under_m = 1;
      if (do_pop) begin
        h = mq.pop_front();
        sb.push_back(h == o);
        if (h == o) begin
          if (pass_m < int'(CMAX)) pass_m++;
        end else begin
          if (fail_m < int'(CMAX)) fail_m++;
          if (!err_m) begin ffo_m = o; ffe_m = h; end
          err_m = 1;
        end
      end
      if (do_push) mq.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, '0, 0, '0, 0);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  task automatic async_reset();
    @(negedge clk);
    obs_valid = 1'b1; exp_valid = 1'b1;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_pending", pending, 0);
    chk("async_ready", exp_ready, 1);
    chk("async_pass", pass_count, 0);
    chk("async_sticky", {underflow, error_sticky}, 0);
    @(negedge clk);
    rst_n = 1'b1; obs_valid = 1'b0; exp_valid = 1'b0;
  endtask

  // Monitor: consume scoreboard entries on pulses and compare the model state.
  initial begin
    bit want;
    forever begin
      @(posedge clk);
      #1;
      if (match || mismatch) begin
        if (sb.size() == 0) begin
          chk("unexpected_pulse", {match, mismatch}, 0);
        end else begin
          want = sb.pop_front();
          chk("pulse_kind", {match, mismatch}, {want, !want});
        end
      end else if (sb.size() > 0) begin
        want = sb.pop_front();
        chk("missing_pulse", {match, mismatch}, {want, !want});
      end
      chk("pending", pending, mq.size());
      chk("exp_ready", exp_ready, mq.size() < DEPTH);
      chk("pass_count", pass_count, pass_m);
      chk("fail_count", fail_count, fail_m);
      chk("underflow", underflow, under_m);
      chk("error_sticky", error_sticky, err_m);
      chk("first_fail_obs", first_fail_obs, ffo_m);
      chk("first_fail_exp", first_fail_exp, ffe_m);
    end
  end

  initial begin
    alu_resp_t e, o;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_pending", pending, 0);
    chk("rst_ready", exp_ready, 1);
    chk("rst_pulses", {match, mismatch, underflow, error_sticky}, 0);
    rst_n = 1'b1;

    // Basic match
    drive(1, mk(32'hFFFF_FFFF, 3'b001), 0, '0, 0);
    drive(0, '0, 1, mk(32'hFFFF_FFFF, 3'b001), 0);
    after_edge();
    chk("t1_match", match, 1);
    chk("t1_pass", pass_count, 1);

    // First mismatch and capture
    drive(1, mk(32'h0, 3'b000), 0, '0, 0);
    drive(0, '0, 1, mk(32'h1, 3'b000), 0);
    after_edge();
    chk("t2_mismatch", mismatch, 1);
    chk("t2_fail", fail_count, 1);
    chk("t2_sticky", error_sticky, 1);
    chk("t2_ffobs", first_fail_obs, {3'b000, 32'h1});

    // Second mismatch leaves capture alone
    drive(1, mk(32'hAAAA_AAAA, 3'b010), 0, '0, 0);
    drive(0, '0, 1, mk(32'h5555_5555, 3'b010), 0);
    after_edge();
    chk("t5_fail", fail_count, 2);
    chk("t5_ffobs", first_fail_obs, {3'b000, 32'h1});
    chk("t5_ffexp", first_fail_exp, {3'b000, 32'h0});

    // Fill, then refused push alongside a pop
    for (int i = 0; i < DEPTH; i++) drive(1, mk(32'h100 + i, 3'(i)), 0, '0, 0);
    after_edge();
    chk("t3_full", pending, 4);
    chk("t3_ready", exp_ready, 0);
    drive(1, mk(32'hDEAD, 3'b111), 1, mk(32'h100, 3'd0), 0);
    after_edge();
    chk("t3_refused", pending, 3);
    for (int i = 1; i < DEPTH; i++) drive(0, '0, 1, mk(32'h100 + i, 3'(i)), 0);

    // Underflow with concurrent push
    drive(1, mk(32'h77, 3'b100), 1, mk(32'h77, 3'b100), 0);
    after_edge();
    chk("t4_underflow", underflow, 1);
    chk("t4_pending", pending, 1);
    chk("t4_fail", fail_count, 2);
    drive(0, '0, 1, mk(32'h77, 3'b100), 0);

    // Clear with pending entries and a concurrent obs
    drive(1, mk(32'h1, 3'b0), 0, '0, 0);
    drive(1, mk(32'h2, 3'b0), 0, '0, 0);
    drive(1, mk(32'h3, 3'b0), 1, mk(32'h1, 3'b0), 1);
    after_edge();
    chk("t6_pending", pending, 0);
    chk("t6_counts", {pass_count, fail_count}, 0);
    chk("t6_nopulse", {match, mismatch, underflow, error_sticky}, 0);

    // Asynchronous reset mid-burst
    drive(1, mk(32'h9, 3'b0), 0, '0, 0);
    drive(1, mk(32'hA, 3'b0), 1, mk(32'h9, 3'b0), 0);
    async_reset();
    idle(1);

    // Saturation of the pass counter
    for (int i = 0; i < 20; i++) begin
      drive(1, mk(32'(i), 3'b011), 0, '0, 0);
      drive(0, '0, 1, mk(32'(i), 3'b011), 0);
    end
    after_edge();
    chk("sat_pass", pass_count, CMAX);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      e = mk($urandom, 3'($urandom_range(0, 7)));
      if (mq.size() > 0 && $urandom_range(0, 3) != 0) o = mq[0];
      else o = mk($urandom, 3'($urandom_range(0, 7)));
      drive($urandom_range(0, 1), e, $urandom_range(0, 1), o, $urandom_range(0, 59) == 0);
    end
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
